fetch_pair_buffer: RTL and testbench
====================================

FETCH_PAIR_BUFFER -- requirements
Module: fetch_pair_buffer

Interface
REQ-001 Parameters (name, default, meaning):
- DEPTH, 8, instruction FIFO entries (power of two, >=4).
- RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 Ports (name, direction, width, meaning):
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- fetch_en  in  1  permits new memory requests.
- redirect  in  1  one-cycle pulse; flush and refetch from redirect_pc.
- redirect_pc  in  32  new fetch address, word aligned.
- mem_req  out  1  memory read request, held until mem_ack.
- mem_addr  out  32  request address, stable while mem_req is high.
- mem_ack  in  1  one-cycle response strobe.
- mem_rdata  in  32  instruction word, valid with mem_ack.
- freeze1  in  1  scheduler lane-1 freeze.
- freeze2  in  1  scheduler lane-2 freeze.
- instruction0  out  32  oldest buffered word, or 32'h0 if none.
- instruction1  out  32  second-oldest word, or 32'h0 if fewer than two.
- nothing_filled  out  1  high when FIFO holds zero entries.
- count  out  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-003 Instruction output: instruction0/instruction1/nothing_filled are combinational from FIFO head; no added latency.
REQ-004 Pop rule: when freeze1==0 and freeze2==0, pop min(count,2) entries at the clock edge; any freeze high pops nothing.
REQ-005 Pop and push in the same cycle are both applied; count_next = count + push - pop.
REQ-006 FSM states: S_IDLE, S_REQ, S_DISCARD.
REQ-007 S_IDLE -> S_REQ when fetch_en==1, redirect==0, and count + pending pop-adjusted occupancy < DEPTH (evaluated as count < DEPTH); mem_req=0 in S_IDLE.
REQ-008 S_REQ: mem_req=1, mem_addr=pc; on mem_ack push mem_rdata, pc += 4, return to S_IDLE.
REQ-009 Single outstanding request only; mem_req never asserted in S_IDLE.
REQ-010 redirect in S_IDLE or coincident with mem_ack in S_REQ: FIFO emptied, pc = redirect_pc, response data (if any) discarded, next state S_IDLE.
REQ-011 redirect in S_REQ without mem_ack: FIFO emptied, pc = redirect_pc, go S_DISCARD.
REQ-012 S_DISCARD: mem_req stays 1 with old mem_addr; on mem_ack data dropped, go S_IDLE; further redirect updates pc only.
REQ-013 redirect overrides same-cycle pop and push; count becomes 0 next cycle.
REQ-014 Full: count==DEPTH blocks new request; an in-flight ack is always accepted since request issue required count<DEPTH and pops only reduce count.
REQ-015 Pointers wrap modulo DEPTH; count saturates at no value (overflow/underflow impossible by REQ-004/REQ-014).
REQ-016 fetch_en deassertion stops new requests only; in-flight request completes normally.

Reset
REQ-017 On rst==1 at clock edge: state=S_IDLE, pc=RESET_PC, read/write pointers=0, count=0, mem_req=0, nothing_filled=1, instruction0=instruction1=0.
REQ-018 Reset mid-request abandons it; a mem_ack arriving in the first cycle after reset is ignored (state S_IDLE).

Structure
REQ-019 State enum and RESET_PC default shall live in the shared core package used by the scheduling logic.
REQ-020 One sub-module: fifo_mem (DEPTH x 32 storage, one write port, two read ports at head and head+1).

Verification
REQ-021 Reset, fetch_en=1, memory acks every 2nd cycle with word = addr|1 -> mem_addr 0,4,8..., FIFO fills, nothing_filled drops one cycle after first ack.
REQ-022 Buffer holds 3 words (A,B,C), freezes low -> next cycle instruction0=C, instruction1=0, count=1.
REQ-023 freeze1=1 for 4 cycles with 8 buffered -> outputs unchanged, mem_req stays 0, count=8.
REQ-024 redirect to 0x100 while mem_req pending, ack 3 cycles later with 0xDEAD -> 0xDEAD never appears, next mem_addr=0x100.
REQ-025 Simultaneous ack and pop of 2 at count=2 -> count=1, instruction0=acked word.
REQ-026 rst asserted during S_REQ -> mem_req=0 next cycle, count=0, mem_addr=RESET_PC on next request.

Source files
------------

// File: rtl/fetch_pair_buffer_pkg.sv
// rtl/fetch_pair_buffer_pkg.sv - shared fetch/scheduler constants, state encoding and pop helper
package fetch_pair_buffer_pkg;

    // Fetch FSM state encoding (kept as plain constants for legacy tools)
    typedef logic [1:0] fpb_state_t;
    localparam fpb_state_t S_IDLE    = 2'd0;
    localparam fpb_state_t S_REQ     = 2'd1;
    localparam fpb_state_t S_DISCARD = 2'd2;

    // First fetch address after reset and the sequential fetch stride
    localparam logic [31:0] FPB_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] FPB_PC_STEP  = 32'd4;

    // Number of words the dual-issue scheduler consumes this cycle:
    // any lane freeze stalls both lanes, otherwise take up to two.
    function automatic logic [1:0] pair_pop_count(
        input logic frozen,
        input logic has_one,
        input logic has_two
    );
        if (frozen)  return 2'd0;
        if (has_two) return 2'd2;
        if (has_one) return 2'd1;
        return 2'd0;
    endfunction

endpackage

// File: rtl/fetch_pair_buffer_fifo_mem.sv
// rtl/fetch_pair_buffer_fifo_mem.sv - DEPTH x 32 storage, one write port, reads at head and head+1
module fetch_pair_buffer_fifo_mem #(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [31:0]   i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [31:0]   o_rdata0,
    output logic [31:0]   o_rdata1
);

    logic [31:0]   r_mem [DEPTH];
    logic [AW-1:0] w_raddr1;

    // Second read port looks one slot past the head, wrapping naturally
    assign w_raddr1 = i_raddr + AW'(1);

    // Store the fetched word at the tail slot
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata0 = r_mem[i_raddr];
    assign o_rdata1 = r_mem[w_raddr1];

endmodule

// File: rtl/fetch_pair_buffer.sv
// rtl/fetch_pair_buffer.sv - single-outstanding instruction fetch feeding a two-wide issue FIFO
module fetch_pair_buffer
    import fetch_pair_buffer_pkg::*;
#(
    parameter int          DEPTH    = 8,
    parameter logic [31:0] RESET_PC = FPB_RESET_PC
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   fetch_en,
    input  logic                   redirect,
    input  logic [31:0]            redirect_pc,
    output logic                   mem_req,
    output logic [31:0]            mem_addr,
    input  logic                   mem_ack,
    input  logic [31:0]            mem_rdata,
    input  logic                   freeze1,
    input  logic                   freeze2,
    output logic [31:0]            instruction0,
    output logic [31:0]            instruction1,
    output logic                   nothing_filled,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
    localparam logic [CW-1:0] C_TWO   = CW'(2);

    fpb_state_t    r_state;
    logic [31:0]   r_pc;
    logic [31:0]   r_addr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;

    logic          w_push;
    logic [1:0]    w_pop_cnt;
    logic [31:0]   w_rd0;
    logic [31:0]   w_rd1;
    logic          w_has_one;
    logic          w_has_two;

    assign w_has_one = (r_count != '0);
    assign w_has_two = (r_count >= C_TWO);

    // Words consumed by the scheduler this cycle
    always_comb begin
        w_pop_cnt = pair_pop_count(freeze1 | freeze2, w_has_one, w_has_two);
    end

    // Only a live (non-discarded, non-redirected) response is written
    assign w_push = (r_state == S_REQ) && mem_ack && !redirect;

    // Fetch FSM: issue one request at a time, drop the response after a redirect
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
            r_addr  <= RESET_PC;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (redirect) begin
                        r_pc <= redirect_pc;
                    end else if (fetch_en && (r_count < C_DEPTH)) begin
                        r_addr  <= r_pc;
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (redirect) begin
                        r_pc    <= redirect_pc;
                        r_state <= mem_ack ? S_IDLE : S_DISCARD;
                    end else if (mem_ack) begin
                        r_pc    <= r_pc + FPB_PC_STEP;
                        r_state <= S_IDLE;
                    end
                end
                S_DISCARD: begin
                    if (redirect) begin
                        r_pc <= redirect_pc;
                    end
                    if (mem_ack) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // FIFO bookkeeping: redirect flushes, otherwise push and pop both apply
    always_ff @(posedge clk) begin
        if (rst || redirect) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_rd_ptr <= r_rd_ptr + AW'(w_pop_cnt);
            r_wr_ptr <= r_wr_ptr + AW'(w_push);
            r_count  <= r_count + CW'(w_push) - CW'(w_pop_cnt);
        end
    end

    fetch_pair_buffer_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo_mem (
        .clk      (clk),
        .i_we     (w_push),
        .i_waddr  (r_wr_ptr),
        .i_wdata  (mem_rdata),
        .i_raddr  (r_rd_ptr),
        .o_rdata0 (w_rd0),
        .o_rdata1 (w_rd1)
    );

    assign mem_req        = (r_state == S_REQ) || (r_state == S_DISCARD);
    assign mem_addr       = r_addr;
    assign nothing_filled = !w_has_one;
    assign instruction0   = w_has_one ? w_rd0 : 32'h0;
    assign instruction1   = w_has_two ? w_rd1 : 32'h0;
    assign count          = r_count;

endmodule

// File: tb/tb_fetch_pair_buffer.sv
// tb/tb_fetch_pair_buffer.sv - randomized and directed checks against a queue-based fetch model
module tb_fetch_pair_buffer;

    localparam int          DEPTH    = 8;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_en;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        freeze1;
    logic        freeze2;
    logic [31:0] instruction0;
    logic [31:0] instruction1;
    logic        nothing_filled;
    logic [3:0]  count;

    always #5 clk = ~clk;

    fetch_pair_buffer #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_en       (fetch_en),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata),
        .freeze1        (freeze1),
        .freeze2        (freeze2),
        .instruction0   (instruction0),
        .instruction1   (instruction1),
        .nothing_filled (nothing_filled),
        .count          (count)
    );

    int checks = 0;
    int errors = 0;

    // Reference: buffered words, whether a request is outstanding, whether
    // its response must be thrown away, next fetch pc and the request address.
    logic [31:0] q[$];
    logic        m_busy;
    logic        m_drop;
    logic [31:0] m_pc;
    logic [31:0] m_addr;
    logic        seen;
    logic [31:0] acked[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic model_step();
        int sz;
        int pops;
        if (rst) begin
            q.delete();
            m_busy = 1'b0;
            m_drop = 1'b0;
            m_pc   = RESET_PC;
            m_addr = RESET_PC;
            return;
        end
        sz   = q.size();
        pops = (freeze1 || freeze2) ? 0 : ((sz >= 2) ? 2 : sz);
        if (redirect) begin
            q.delete();
            m_pc = redirect_pc;
            if (m_busy) begin
                if (mem_ack) begin
                    m_busy = 1'b0;
                    m_drop = 1'b0;
                end else begin
                    m_drop = 1'b1;
                end
            end
        end else begin
            for (int i = 0; i < pops; i++) void'(q.pop_front());
            if (m_busy) begin
                if (mem_ack) begin
                    if (!m_drop) begin
                        q.push_back(mem_rdata);
                        m_pc = m_pc + 32'd4;
                    end
                    m_busy = 1'b0;
                    m_drop = 1'b0;
                end
            end else if (fetch_en && sz < DEPTH) begin
                m_busy = 1'b1;
                m_addr = m_pc;
            end
        end
    endtask

    task automatic check_all();
        chk("count", 32'(count), 32'(q.size()));
        chk("nothing_filled", 32'(nothing_filled), 32'(q.size() == 0));
        chk("instruction0", instruction0, (q.size() > 0) ? q[0] : 32'h0);
        chk("instruction1", instruction1, (q.size() > 1) ? q[1] : 32'h0);
        chk("mem_req", 32'(mem_req), 32'(m_busy));
        if (m_busy) chk("mem_addr", mem_addr, m_addr);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    // Memory that answers every second cycle of an outstanding request
    task automatic auto_ack();
        mem_ack   = m_busy && seen;
        mem_rdata = mem_addr | 32'h1;
        seen      = m_busy && !mem_ack;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time exceeded");
        $fatal(1);
    end

    initial begin
        logic        first;
        logic [31:0] r;
        int          n;

        rst = 1'b1; fetch_en = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        mem_ack = 1'b0; mem_rdata = 32'h0; freeze1 = 1'b0; freeze2 = 1'b0;
        seen = 1'b0;
        m_busy = 1'b0; m_drop = 1'b0; m_pc = RESET_PC; m_addr = RESET_PC;
        @(negedge clk);
        tick();
        tick();
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_nothing_filled", 32'(nothing_filled), 32'd1);
        chk("reset_mem_req", 32'(mem_req), 32'd0);
        chk("reset_instruction0", instruction0, 32'h0);
        chk("reset_instruction1", instruction1, 32'h0);

        // Sequential fill with lanes frozen
        rst = 1'b0; fetch_en = 1'b1; freeze1 = 1'b1; first = 1'b1;
        for (n = 0; n < 200 && q.size() < DEPTH; n++) begin
            auto_ack();
            if (mem_ack) begin
                acked.push_back(mem_addr);
                if (first) chk("nf_before_first_ack", 32'(nothing_filled), 32'd1);
            end
            tick();
            if (mem_ack && first) begin
                chk("nf_after_first_ack", 32'(nothing_filled), 32'd0);
                first = 1'b0;
            end
        end
        mem_ack = 1'b0;
        chk("fill_done", 32'(q.size() == DEPTH), 32'd1);
        chk("fill_addr0", (acked.size() > 0) ? acked[0] : 32'hFFFF_FFFF, 32'h0);
        chk("fill_addr1", (acked.size() > 1) ? acked[1] : 32'hFFFF_FFFF, 32'h4);
        chk("fill_addr2", (acked.size() > 2) ? acked[2] : 32'hFFFF_FFFF, 32'h8);
        chk("full_count", 32'(count), 32'd8);
        chk("full_instruction0", instruction0, 32'h1);
        chk("full_instruction1", instruction1, 32'h5);

        // Frozen while full
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("frozen_instruction0", instruction0, 32'h1);
            chk("frozen_mem_req", 32'(mem_req), 32'd0);
            chk("frozen_count", 32'(count), 32'd8);
        end

        // Three words then pop two, leaving the third alone
        redirect = 1'b1; redirect_pc = 32'h200;
        tick();
        redirect = 1'b0;
        chk("flush_count", 32'(count), 32'd0);
        seen = 1'b0;
        for (n = 0; n < 100 && q.size() < 3; n++) begin
            auto_ack();
            tick();
        end
        mem_ack = 1'b0; fetch_en = 1'b0;
        chk("three_loaded", 32'(q.size()), 32'd3);
        freeze1 = 1'b0;
        tick();
        chk("pair_pop_instruction0", instruction0, 32'h209);
        chk("pair_pop_instruction1", instruction1, 32'h0);
        chk("pair_pop_count", 32'(count), 32'd1);

        // Ack coincident with a pop of two at count 2
        freeze1 = 1'b1; fetch_en = 1'b1; seen = 1'b0;
        for (n = 0; n < 100 && !(q.size() == 2 && m_busy); n++) begin
            if (q.size() < 2) auto_ack();
            else mem_ack = 1'b0;
            tick();
        end
        chk("ack_pop_setup", 32'(q.size() == 2 && m_busy), 32'd1);
        mem_ack = 1'b1; mem_rdata = 32'hABC0_0001; freeze1 = 1'b0;
        tick();
        mem_ack = 1'b0; freeze1 = 1'b1;
        chk("ack_pop_count", 32'(count), 32'd1);
        chk("ack_pop_instruction0", instruction0, 32'hABC0_0001);
        chk("ack_pop_instruction1", instruction1, 32'h0);

        // Redirect while a request is outstanding; late response is dropped
        for (n = 0; n < 20 && !m_busy; n++) tick();
        chk("redir_setup_busy", 32'(m_busy), 32'd1);
        redirect = 1'b1; redirect_pc = 32'h100;
        tick();
        redirect = 1'b0;
        chk("redir_count", 32'(count), 32'd0);
        chk("redir_discard_req", 32'(mem_req), 32'd1);
        tick();
        tick();
        mem_ack = 1'b1; mem_rdata = 32'h0000_DEAD;
        tick();
        mem_ack = 1'b0;
        chk("drop_count", 32'(count), 32'd0);
        chk("drop_instruction0", instruction0, 32'h0);
        for (n = 0; n < 20 && !m_busy; n++) tick();
        chk("redir_next_addr", mem_addr, 32'h100);

        // Reset in the middle of a request
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mid_count", 32'(count), 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'h0000_0BAD;
        tick();
        mem_ack = 1'b0;
        chk("rst_ack_ignored_count", 32'(count), 32'd0);
        for (n = 0; n < 20 && !m_busy; n++) tick();
        chk("rst_next_addr", mem_addr, RESET_PC);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 299) == 0);
            fetch_en  = ($urandom_range(0, 9) != 0);
            freeze1   = ($urandom_range(0, 3) == 0);
            freeze2   = ($urandom_range(0, 3) == 0);
            redirect  = ($urandom_range(0, 39) == 0);
            r         = $urandom();
            redirect_pc = r & ~32'h3;
            mem_ack   = m_busy && ($urandom_range(0, 2) == 0);
            mem_rdata = $urandom();
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
